// File: rtl/shift_pkg.sv
// Shared constants for the shift_midpoint_gen2 block: shift mode encodings
// and the default debounce length.
package shift_pkg;

  localparam logic [1:0] MODE_SHL = 2'b00;
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 10;

endpackage

// File: rtl/shift_midpoint_gen2_if.sv
// Board-side bundle of shift_midpoint_gen2: raw button/switch inputs,
// mode select and the LED / serial outputs.
interface shift_midpoint_gen2_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);

  logic             btn0;
  logic             switch0;
  logic             switch1;
  logic [1:0]       mode;
  logic [WIDTH-1:0] parallelout;
  logic             serialout;
  logic [CNT_W-1:0] shift_count;
  logic             frame_done;

  modport master (
    output btn0, switch0, switch1, mode,
    input  parallelout, serialout, shift_count, frame_done
  );

  modport slave (
    input  btn0, switch0, switch1, mode,
    output parallelout, serialout, shift_count, frame_done
  );

endinterface

// File: rtl/input_sync_debounce.sv
// Two-flop synchroniser plus debouncer for one asynchronous board input;
// emits a conditioned level and single-cycle edge pulses aligned with its flips.
module input_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic noisy,
  output logic conditioned,
  output logic posedge_pulse,
  output logic negedge_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          rise_r;
  logic          fall_r;

  // Synchronise, count stable-but-different cycles, flip level when the count is met.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= '0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= noisy;
      sync2_r <= sync1_r;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == LAST) begin
          level_r <= sync2_r;
          cnt_r   <= '0;
          rise_r  <= sync2_r;
          fall_r  <= ~sync2_r;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign conditioned   = level_r;
  assign posedge_pulse = rise_r;
  assign negedge_pulse = fall_r;

endmodule

// File: rtl/shift_midpoint_gen2.sv
// Parametrised shift register fed by conditioned button/switch inputs, with
// four shift modes, a shift counter and a one-cycle frame-done pulse.
module shift_midpoint_gen2
  import shift_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter logic [WIDTH-1:0] LOAD_VALUE      = WIDTH'(8'hA5),
  parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int               CNT_W           = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  shift_midpoint_gen2_if.slave bus
);

  localparam logic [CNT_W-1:0] WRAP = CNT_W'(WIDTH);

  logic btn_level_s, btn_rise_s, btn_fall_s;
  logic sw0_level_s, sw0_rise_s, sw0_fall_s;
  logic sw1_level_s, sw1_rise_s, sw1_fall_s;

  logic [WIDTH-1:0] parallelout_r;
  logic [CNT_W-1:0] shift_count_r;
  logic             frame_done_r;
  logic [WIDTH-1:0] shift_next_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             load_s;
  logic             shift_s;
  logic             unused_s;

  input_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
    .clk(clk), .rst_n(rst_n), .noisy(bus.btn0),
    .conditioned(btn_level_s), .posedge_pulse(btn_rise_s), .negedge_pulse(btn_fall_s)
  );

  input_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_switch0 (
    .clk(clk), .rst_n(rst_n), .noisy(bus.switch0),
    .conditioned(sw0_level_s), .posedge_pulse(sw0_rise_s), .negedge_pulse(sw0_fall_s)
  );

  input_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_switch1 (
    .clk(clk), .rst_n(rst_n), .noisy(bus.switch1),
    .conditioned(sw1_level_s), .posedge_pulse(sw1_rise_s), .negedge_pulse(sw1_fall_s)
  );

  assign unused_s = &{1'b0, btn_level_s, btn_fall_s, sw0_rise_s, sw0_fall_s,
                      sw1_level_s, sw1_fall_s};

  // A load pulse always beats a coincident shift pulse.
  assign load_s    = btn_rise_s;
  assign shift_s   = sw1_rise_s & ~btn_rise_s;
  assign cnt_inc_s = shift_count_r + CNT_W'(1);

  // Candidate register value for the currently selected mode.
  always_comb begin
    shift_next_s = parallelout_r;
    case (bus.mode)
      MODE_SHL: shift_next_s = {parallelout_r[WIDTH-2:0], sw0_level_s};
      MODE_SHR: shift_next_s = {sw0_level_s, parallelout_r[WIDTH-1:1]};
      MODE_ROL: shift_next_s = {parallelout_r[WIDTH-2:0], parallelout_r[WIDTH-1]};
      MODE_ROR: shift_next_s = {parallelout_r[0], parallelout_r[WIDTH-1:1]};
      default:  shift_next_s = parallelout_r;
    endcase
  end

  // Shift register, shift counter and frame-done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parallelout_r <= '0;
      shift_count_r <= '0;
      frame_done_r  <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (load_s) begin
        parallelout_r <= LOAD_VALUE;
        shift_count_r <= '0;
      end else if (shift_s) begin
        parallelout_r <= shift_next_s;
        if (cnt_inc_s == WRAP) begin
          shift_count_r <= '0;
          frame_done_r  <= 1'b1;
        end else begin
          shift_count_r <= cnt_inc_s;
        end
      end else begin
        parallelout_r <= parallelout_r;
      end
    end
  end

  assign bus.parallelout = parallelout_r;
  assign bus.serialout   = bus.mode[0] ? parallelout_r[0] : parallelout_r[WIDTH-1];
  assign bus.shift_count = shift_count_r;
  assign bus.frame_done  = frame_done_r;

endmodule

// File: tb/tb_shift_midpoint_gen2.sv
// Scoreboard bench for shift_midpoint_gen2 (WIDTH=8, LOAD_VALUE=A5, DEBOUNCE_CYCLES=3).
module tb_shift_midpoint_gen2;
  import shift_pkg::*;

  localparam int         W  = 8;
  localparam int         CW = 4;
  localparam int         D  = 3;
  localparam logic [7:0] LV = 8'hA5;

  typedef struct {
    logic [7:0] po;
    logic [3:0] cnt;
    int         fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  int   fd_total = 0;
  exp_t sb[$];

  logic [7:0] m_po;
  logic [3:0] m_cnt;
  logic       m_sw0;

  always #10 clk = ~clk;

  shift_midpoint_gen2_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  shift_midpoint_gen2 #(
    .WIDTH(W), .LOAD_VALUE(LV), .DEBOUNCE_CYCLES(D), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always @(negedge clk) if (bus.frame_done === 1'b1) fd_total <= fd_total + 1;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_shift(input logic [7:0] po, input logic [1:0] md,
                                             input logic sw0);
    case (md)
      2'b00:   return {po[6:0], sw0};
      2'b01:   return {sw0, po[7:1]};
      2'b10:   return {po[6:0], po[7]};
      default: return {po[0], po[7:1]};
    endcase
  endfunction

  function automatic logic model_serial(input logic [7:0] po, input logic [1:0] md);
    return md[0] ? po[0] : po[7];
  endfunction

  task automatic set_sw0(input logic v);
    bus.switch0 = v;
    m_sw0 = v;
    repeat (10) @(negedge clk);
  endtask

  // Drive one press (button and/or shift switch), push expectation, then pop and compare.
  task automatic action(input string tag, input logic btn, input logic sw1);
    exp_t e;
    exp_t got;
    int   fd_start;
    e.fd = 0;
    if (btn) begin
      m_po  = LV;
      m_cnt = 4'd0;
    end else if (sw1) begin
      m_po = model_shift(m_po, bus.mode, m_sw0);
      if (m_cnt == 4'd7) begin
        m_cnt = 4'd0;
        e.fd  = 1;
      end else begin
        m_cnt = m_cnt + 4'd1;
      end
    end
    e.po  = m_po;
    e.cnt = m_cnt;
    sb.push_back(e);
    fd_start    = fd_total;
    bus.btn0    = btn;
    bus.switch1 = sw1;
    repeat (10) @(negedge clk);
    bus.btn0    = 1'b0;
    bus.switch1 = 1'b0;
    repeat (10) @(negedge clk);
    if (sb.size() == 0) begin
      check_value({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check_value({tag, "_po"}, 32'(bus.parallelout), 32'(got.po));
      check_value({tag, "_cnt"}, 32'(bus.shift_count), 32'(got.cnt));
      check_value({tag, "_fd"}, 32'(fd_total - fd_start), 32'(got.fd));
      check_value({tag, "_so"}, 32'(bus.serialout), 32'(model_serial(got.po, bus.mode)));
    end
  endtask

  initial begin
    int fd_before;
    rst_n       = 1'b0;
    bus.btn0    = 1'b1;
    bus.switch0 = 1'b0;
    bus.switch1 = 1'b0;
    bus.mode    = MODE_SHL;
    m_po = 8'h00; m_cnt = 4'd0; m_sw0 = 1'b0;

    // Reset with the button held
    repeat (2) @(negedge clk);
    check_value("rst_po", 32'(bus.parallelout), 32'h00);
    check_value("rst_cnt", 32'(bus.shift_count), 32'h0);
    check_value("rst_fd", 32'(bus.frame_done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_value("post_rst_no_load", 32'(bus.parallelout), 32'h00);
    action("load_after_rst", 1'b1, 1'b0);

    // Shift-left of A5 with serial 0
    set_sw0(1'b0);
    action("shl", 1'b0, 1'b1);

    // Shift-right with serial 1, then mode-only change of serialout
    action("load_shr", 1'b1, 1'b0);
    bus.mode = MODE_SHR;
    set_sw0(1'b1);
    action("shr", 1'b0, 1'b1);
    bus.mode = MODE_SHL;
    #1;
    check_value("so_follows_mode", 32'(bus.serialout), 32'(model_serial(m_po, MODE_SHL)));

    // Rotates from A5
    action("load_rol", 1'b1, 1'b0);
    bus.mode = MODE_ROL;
    action("rol", 1'b0, 1'b1);
    action("load_ror", 1'b1, 1'b0);
    bus.mode = MODE_ROR;
    action("ror", 1'b0, 1'b1);

    // Full frame of eight rotates
    action("load_frame", 1'b1, 1'b0);
    bus.mode = MODE_ROL;
    for (int i = 0; i < 8; i++) action($sformatf("frame%0d", i), 1'b0, 1'b1);

    // Glitch shorter than the debounce window
    bus.switch1 = 1'b1;
    repeat (2) @(negedge clk);
    bus.switch1 = 1'b0;
    repeat (12) @(negedge clk);
    check_value("glitch_po", 32'(bus.parallelout), 32'(m_po));
    check_value("glitch_cnt", 32'(bus.shift_count), 32'(m_cnt));

    // Simultaneous load and shift
    action("pre_simul", 1'b0, 1'b1);
    action("simul", 1'b1, 1'b1);

    // Reset in the middle of a switch1 debounce
    for (int i = 0; i < 3; i++) action($sformatf("pre_rst%0d", i), 1'b0, 1'b1);
    fd_before   = fd_total;
    bus.switch1 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n       = 1'b0;
    bus.switch1 = 1'b0;
    repeat (2) @(negedge clk);
    check_value("mid_rst_po", 32'(bus.parallelout), 32'h00);
    check_value("mid_rst_cnt", 32'(bus.shift_count), 32'h0);
    check_value("mid_rst_fd", 32'(bus.frame_done), 32'h0);
    check_value("mid_rst_so", 32'(bus.serialout), 32'h0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_value("no_pending_po", 32'(bus.parallelout), 32'h00);
    check_value("no_pending_cnt", 32'(bus.shift_count), 32'h0);
    check_value("no_pending_fd", 32'(fd_total - fd_before), 32'h0);
    check_value("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
